// File: rtl/pipe_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_if
// Bundles the upstream/downstream handshake, flush and status signals of one
// elastic pipeline-stage register.
//   in_valid / in_ready / in_data     : upstream valid/ready handshake + payload
//   flush                             : discard everything held by the stage
//   out_valid / out_ready / out_data  : downstream valid/ready handshake + payload
//   occupancy                         : payloads currently held (0..2)
//   bp_cycles                         : saturating count of stalled output cycles
// Modports: master = the environment around the stage, slave = the stage itself.
// -----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bp_cycles;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy, bp_cycles
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy, bp_cycles
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Elastic pipeline-stage register with valid/ready handshake, optional skid
// entry, flush and a saturating backpressure counter.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : pipe_skid_reg_if.slave (handshakes, flush, occupancy, bp_cycles)
// Parameters:
//   WIDTH : payload width
//   SKID  : 1 = main + skid entries, in_ready driven from a flop
//           0 = main entry only, in_ready combinational from out_ready
//   CNT_W : backpressure counter width
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int WIDTH = 64,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             reset,
    pipe_skid_reg_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;
    logic [CNT_W-1:0] r_bp_cnt;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_m_valid_nxt;
    logic [WIDTH-1:0] w_m_data_nxt;
    logic             w_s_valid_nxt;
    logic [WIDTH-1:0] w_s_data_nxt;

    // With a skid entry, in_ready only depends on the skid flop, so the ready
    // path between stages is cut; without it, ready passes straight through.
    generate
        if (SKID != 32'sd0) begin : g_skid_ready
            assign w_in_ready = ~r_s_valid;
        end else begin : g_pass_ready
            assign w_in_ready = ~r_m_valid | bus.out_ready;
        end
    endgenerate

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = r_m_valid & bus.out_ready;

    // Next-state of main and skid entries; flush wins over any transfer.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;
        w_s_valid_nxt = r_s_valid;
        w_s_data_nxt  = r_s_data;
        if (bus.flush) begin
            w_m_valid_nxt = 1'b0;
            w_m_data_nxt  = '0;
            w_s_valid_nxt = 1'b0;
            w_s_data_nxt  = '0;
        end else if (w_out_fire && r_s_valid) begin
            // Skid refills main; in_ready is low here so nothing can arrive.
            w_m_data_nxt  = r_s_data;
            w_s_valid_nxt = 1'b0;
        end else if (w_in_fire && (!r_m_valid || w_out_fire)) begin
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = bus.in_data;
        end else if (w_in_fire && (SKID != 32'sd0)) begin
            // Main is full and stalled: park the payload in the skid.
            w_s_valid_nxt = 1'b1;
            w_s_data_nxt  = bus.in_data;
        end else if (w_out_fire) begin
            w_m_valid_nxt = 1'b0;
        end else begin
            w_m_valid_nxt = r_m_valid;
        end
    end

    // Payload registers; data is zeroed on reset so bubbles read as NOPs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_m_data  <= w_m_data_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_s_data  <= w_s_data_nxt;
        end
    end

    // Saturating stall counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bp_cnt <= '0;
        end else if (r_m_valid && !bus.out_ready && (r_bp_cnt != CNT_MAX)) begin
            r_bp_cnt <= r_bp_cnt + CNT_ONE;
        end else begin
            r_bp_cnt <= r_bp_cnt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_m_valid;
    assign bus.out_data  = r_m_data;
    assign bus.occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};
    assign bus.bp_cycles = r_bp_cnt;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Two stages side by side: u_a (SKID=1, CNT_W=4) and u_b (SKID=0, CNT_W=16).
// Each is compared every cycle against a queue model of the held payloads,
// plus directed checks of the documented scenarios and a random phase.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    pipe_skid_reg_if #(.WIDTH(64), .CNT_W(4))  ia ();
    pipe_skid_reg_if #(.WIDTH(64), .CNT_W(16)) ib ();

    pipe_skid_reg #(.WIDTH(64), .SKID(1), .CNT_W(4))  u_a (.clk(clk), .reset(rst), .bus(ia));
    pipe_skid_reg #(.WIDTH(64), .SKID(0), .CNT_W(16)) u_b (.clk(clk), .reset(rst), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ordered list of held payloads, value shown downstream,
    // and stall counter.
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] mda = 64'd0;
    logic [63:0] mdb = 64'd0;
    int          bpa = 0;
    int          bpb = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit fa_in, fa_out, fb_in, fb_out;
        fa_in  = ia.in_valid && (qa.size() < 2);
        fa_out = (qa.size() > 0) && ia.out_ready;
        fb_in  = ib.in_valid && ((qb.size() == 0) || ib.out_ready);
        fb_out = (qb.size() > 0) && ib.out_ready;
        if ((qa.size() > 0) && !ia.out_ready && (bpa < 15))    bpa++;
        if ((qb.size() > 0) && !ib.out_ready && (bpb < 65535)) bpb++;
        if (rst) begin
            qa.delete(); qb.delete();
            mda = 64'd0; mdb = 64'd0; bpa = 0; bpb = 0;
        end else begin
            if (ia.flush) begin
                qa.delete(); mda = 64'd0;
            end else begin
                if (fa_out) void'(qa.pop_front());
                if (fa_in)  qa.push_back(ia.in_data);
                if (qa.size() > 0) mda = qa[0];
            end
            if (ib.flush) begin
                qb.delete(); mdb = 64'd0;
            end else begin
                if (fb_out) void'(qb.pop_front());
                if (fb_in)  qb.push_back(ib.in_data);
                if (qb.size() > 0) mdb = qb[0];
            end
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model, return just after the edge.
    task automatic cycle();
        @(negedge clk);
        if (chk_en) begin
            chk("a_in_ready",  ia.in_ready,  (qa.size() < 2));
            chk("a_out_valid", ia.out_valid, (qa.size() > 0));
            chk("a_out_data",  ia.out_data,  mda);
            chk("a_occupancy", ia.occupancy, qa.size());
            chk("a_bp_cycles", ia.bp_cycles, bpa);
            chk("b_in_ready",  ib.in_ready,  ((qb.size() == 0) || ib.out_ready));
            chk("b_out_valid", ib.out_valid, (qb.size() > 0));
            chk("b_out_data",  ib.out_data,  mdb);
            chk("b_occupancy", ib.occupancy, qb.size());
            chk("b_bp_cycles", ib.bp_cycles, bpb);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ia.in_valid = 1'b0; ia.in_data = 64'd0; ia.flush = 1'b0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = 64'd0; ib.flush = 1'b0; ib.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_a_in_ready",  ia.in_ready,  64'd1);
        chk("rst_a_out_valid", ia.out_valid, 64'd0);
        chk("rst_a_out_data",  ia.out_data,  64'd0);
        chk("rst_a_occupancy", ia.occupancy, 64'd0);
        chk("rst_a_bp_cycles", ia.bp_cycles, 64'd0);
        chk("rst_b_in_ready",  ib.in_ready,  64'd1);

        // Streaming 1..8 through the skid stage with out_ready high.
        ia.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ia.in_valid = 1'b1; ia.in_data = 64'(i);
            cycle();
            chk("stream_data",  ia.out_data,  64'(i));
            chk("stream_valid", ia.out_valid, 64'd1);
        end
        ia.in_valid = 1'b0;
        cycle();
        chk("stream_bp", ia.bp_cycles, 64'd0);

        // Backpressure fill/drain: 0xA, 0xB parked, 0xC held, ready after 3 stall cycles.
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1; ia.in_data = 64'hA;
        cycle();
        ia.in_data = 64'hB;
        cycle();
        chk("bp_full_in_ready",  ia.in_ready,  64'd0);
        chk("bp_full_occupancy", ia.occupancy, 64'd2);
        ia.in_data = 64'hC;
        cycle();
        cycle();
        chk("bp_count", ia.bp_cycles, 64'd3);
        ia.out_ready = 1'b1;
        cycle();
        chk("drain_b", ia.out_data, 64'hB);
        cycle();
        chk("drain_c", ia.out_data, 64'hC);
        ia.in_valid = 1'b0;
        cycle();
        chk("drain_empty", ia.out_valid, 64'd0);
        chk("drain_bp",    ia.bp_cycles, 64'd3);

        // SKID=0 pass-through: full main, downstream ready, new input same cycle.
        ib.out_ready = 1'b0; ib.in_valid = 1'b1; ib.in_data = 64'h5;
        cycle();
        ib.out_ready = 1'b1; ib.in_data = 64'h6;
        #1;
        chk("pass_in_ready", ib.in_ready, 64'd1);
        cycle();
        chk("pass_data", ib.out_data, 64'h6);
        ib.in_valid = 1'b0;
        cycle();

        // Flush with the stage full and 0xC presented.
        ia.out_ready = 1'b0; ia.in_valid = 1'b1; ia.in_data = 64'hA;
        cycle();
        ia.in_data = 64'hB;
        cycle();
        ia.in_data = 64'hC; ia.flush = 1'b1;
        cycle();
        ia.flush = 1'b0; ia.in_valid = 1'b0;
        chk("flush_valid", ia.out_valid, 64'd0);
        chk("flush_occ",   ia.occupancy, 64'd0);
        chk("flush_data",  ia.out_data,  64'd0);
        cycle();
        // Flush colliding with an accepted 0xC and an output transfer.
        ia.in_valid = 1'b1; ia.in_data = 64'hA;
        cycle();
        ia.out_ready = 1'b1; ia.in_data = 64'hC; ia.flush = 1'b1;
        cycle();
        ia.flush = 1'b0; ia.in_valid = 1'b0;
        chk("flush2_valid", ia.out_valid, 64'd0);
        chk("flush2_data",  ia.out_data,  64'd0);
        cycle();
        chk("flush2_no_c", ia.out_valid, 64'd0);

        // Counter saturation at 15, kept through flush, cleared by reset.
        ia.out_ready = 1'b0; ia.in_valid = 1'b1; ia.in_data = 64'h3;
        cycle();
        ia.in_valid = 1'b0;
        repeat (20) cycle();
        chk("sat_bp", ia.bp_cycles, 64'd15);
        ia.flush = 1'b1;
        cycle();
        ia.flush = 1'b0;
        chk("sat_after_flush", ia.bp_cycles, 64'd15);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("sat_after_reset", ia.bp_cycles, 64'd0);

        // Reset while two payloads are held, then 0x77 goes through.
        ia.out_ready = 1'b0; ia.in_valid = 1'b1; ia.in_data = 64'h11;
        cycle();
        ia.in_data = 64'h22;
        cycle();
        chk("mid_occ2", ia.occupancy, 64'd2);
        ia.in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_in_ready",  ia.in_ready,  64'd1);
        chk("mid_out_valid", ia.out_valid, 64'd0);
        chk("mid_out_data",  ia.out_data,  64'd0);
        chk("mid_occupancy", ia.occupancy, 64'd0);
        chk("mid_bp",        ia.bp_cycles, 64'd0);
        ia.in_valid = 1'b1; ia.in_data = 64'h77;
        cycle();
        chk("mid_77_valid", ia.out_valid, 64'd1);
        chk("mid_77_data",  ia.out_data,  64'h77);
        ia.in_valid = 1'b0; ia.out_ready = 1'b1;
        cycle();

        // Random traffic on both stages against the model.
        for (int n = 0; n < 400; n++) begin
            ia.in_valid  = ($urandom_range(0, 3) != 0);
            ia.out_ready = ($urandom_range(0, 2) != 0);
            ia.in_data   = {$urandom, $urandom};
            ia.flush     = ($urandom_range(0, 29) == 0);
            ib.in_valid  = ($urandom_range(0, 3) != 0);
            ib.out_ready = ($urandom_range(0, 2) != 0);
            ib.in_data   = {$urandom, $urandom};
            ib.flush     = ($urandom_range(0, 29) == 0);
            rst          = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        ia.in_valid = 1'b0; ia.flush = 1'b0; ib.in_valid = 1'b0; ib.flush = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
